instr_fetch_unit: RTL and testbench

Consumer and driver of the program-counter register. Reads the current PC value, issues in-order instruction-memory requests at that address, and advances the PC register through its datain/enable pair. Buffers returned instructions with their PC for decode. Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: datapath width and instruction alignment.
package riscv_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned INSTR_BYTES   = 4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and head peek.
// Push on full and pop on empty are excluded by the caller's credit scheme.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush has priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: drives the PC register, issues imem requests,
// buffers {pc, instr} for decode and squashes in-flight fetches on redirect.
module instr_fetch_unit #(
    parameter int unsigned XLEN            = riscv_pkg::XLEN,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_value,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    import riscv_pkg::*;

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [OW-1:0]     live;
    logic [CW-1:0]     fifo_count;
    logic [XLEN-1:0]   pend_pc;
    logic [2*XLEN-1:0] out_head;
    logic              issue;
    logic              fire;
    logic              rsp_keep;
    logic              rsp_drop;

    // Pending-PC entries are exactly the requests whose responses will be kept.
    assign issue = !reset && !redirect_valid
                && (outstanding < OW'(MAX_OUTSTANDING))
                && ((32'(fifo_count) + 32'(live)) < FIFO_DEPTH);
    assign fire  = issue && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_value;
    assign pc_enable      = !reset && (redirect_valid || fire);
    assign pc_next        = redirect_valid ? (redirect_pc & ~XLEN'(INSTR_BYTES - 1))
                                           : pc_value + XLEN'(INSTR_BYTES);

    // A response landing in the redirect cycle is already consumed, so it is not dropped later.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(fire) - OW'(imem_rsp_valid);
            if (redirect_valid) begin
                drop_cnt <= outstanding - OW'(imem_rsp_valid);
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fire),
        .push_data (pc_value),
        .pop       (rsp_keep),
        .head      (pend_pc),
        .count     (live)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_out_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep && !redirect_valid),
        .push_data ({pend_pc, imem_rsp_data}),
        .pop       (if_valid && if_ready),
        .head      (out_head),
        .count     (fifo_count)
    );

    assign if_valid = !reset && (fifo_count != '0);
    assign if_pc    = out_head[2*XLEN-1:XLEN];
    assign if_instr = out_head[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register, a 1-cycle imem model
// and a scoreboard checking every instruction handed to decode.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_value;
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] pc_init;
    logic        rsp_en;
    logic [31:0] mem_q[$];
    logic [31:0] mem_a;
    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_value       (pc_value),
        .pc_next        (pc_next),
        .pc_enable      (pc_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0000_0013 + (pc >> 2);
    endfunction

    // PC register driven through pc_next/pc_enable
    always @(posedge clk) begin
        if (reset) pc_value <= pc_init;
        else if (pc_enable) pc_value <= pc_next;
    end

    // In-order imem: answers one cycle after accept unless responses are held
    always @(posedge clk) begin
        if (reset) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
            if (rsp_en && mem_q.size() > 0) begin
                mem_a = mem_q.pop_front();
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(mem_a);
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Decode-side monitor: a pop is a handshake with no flush in the same cycle
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && if_valid && if_ready && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual pc=%h instr=%h required none", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e.pc || if_instr !== e.instr) begin
                        failures++;
                        $display("FAIL sb_pop actual pc=%h instr=%h required pc=%h instr=%h",
                                 if_pc, if_instr, e.pc, e.instr);
                    end
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        pc_init        = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        rsp_en         = 1'b1;
        fork
            monitor_loop();
        join_none

        // Reset
        repeat (3) step();
        imem_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_pc_enable", 32'(pc_enable), 32'd0);

        // Streaming from PC 0
        step();
        reset = 1'b0;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        expect_fetch(32'hC);
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        chk("first_pc_next", pc_next, 32'h4);
        chk("first_pc_enable", 32'(pc_enable), 32'd1);
        chk("first_if_valid", 32'(if_valid), 32'd0);
        step();
        #1;
        chk("stream_c1_if_valid", 32'(if_valid), 32'd0);
        chk("stream_c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stream_c1_req_addr", imem_req_addr, 32'h4);
        step();
        #1;
        chk("stream_c2_if_valid", 32'(if_valid), 32'd1);
        chk("stream_c2_if_pc", if_pc, 32'h0);
        chk("stream_c2_credit_stall", 32'(imem_req_valid), 32'd0);
        repeat (3) step();
        imem_req_ready = 1'b0;
        repeat (6) step();

        // Backpressure from decode
        step();
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (3) step();
        #1;
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_pc_enable", 32'(pc_enable), 32'd0);
        chk("bp_if_valid", 32'(if_valid), 32'd1);
        chk("bp_if_pc", if_pc, 32'h10);
        chk("bp_pc_value", pc_value, 32'h18);
        expect_fetch(32'h10);
        expect_fetch(32'h14);
        expect_fetch(32'h18);
        step();
        if_ready = 1'b1;
        step();
        #1;
        chk("bp_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("bp_resume_addr", imem_req_addr, 32'h18);
        step();
        imem_req_ready = 1'b0;
        repeat (6) step();

        // Redirect with two requests in flight
        step();
        rsp_en         = 1'b0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        expect_fetch(32'h100);
        expect_fetch(32'h104);
        #1;
        chk("redir_pc_next", pc_next, 32'h100);
        chk("redir_pc_enable", 32'(pc_enable), 32'd1);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        #1;
        chk("redir_c3_if_valid", 32'(if_valid), 32'd0);
        step();
        step();
        #1;
        chk("redir_drop_if_valid", 32'(if_valid), 32'd0);
        chk("redir_req_valid_c5", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr_c5", imem_req_addr, 32'h100);
        step();
        step();
        imem_req_ready = 1'b0;
        repeat (6) step();

        // Misaligned redirect with a response arriving in the same cycle
        step();
        if_ready       = 1'b0;
        imem_req_ready = 1'b1;
        expect_fetch(32'h100);
        expect_fetch(32'h104);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        if_ready       = 1'b1;
        #1;
        chk("mis_pc_next", pc_next, 32'h100);
        chk("mis_pc_enable", 32'(pc_enable), 32'd1);
        chk("mis_stale_if_valid", 32'(if_valid), 32'd1);
        chk("mis_stale_if_pc", if_pc, 32'h108);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("mis_flushed_if_valid", 32'(if_valid), 32'd0);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mis_req_addr", imem_req_addr, 32'h100);
        step();
        step();
        imem_req_ready = 1'b0;
        repeat (6) step();

        // PC wrap at the top of the address space
        step();
        reset          = 1'b1;
        pc_init        = 32'hFFFF_FFFC;
        imem_req_ready = 1'b0;
        step();
        step();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0);
        #1;
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0);
        chk("wrap_pc_enable", 32'(pc_enable), 32'd1);
        step();
        #1;
        chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_next_addr", imem_req_addr, 32'h0);
        step();
        imem_req_ready = 1'b0;
        repeat (6) step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
